// File: rtl/fifo_prio_pkg.sv
// Widths and level type shared by the multi-level priority FIFO and its queues.
package fifo_prio_pkg;

  typedef logic [7:0] level_t;

  function automatic int prioWidth(input int numPrio);
    return (numPrio < 2) ? 1 : $clog2(numPrio);
  endfunction

  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Aging disabled still needs a 1-bit counter so the arrays stay legal.
  function automatic int waitWidth(input int ageLimit);
    return (ageLimit < 1) ? 1 : $clog2(ageLimit + 1);
  endfunction

  function automatic level_t clampLevel(input level_t raw, input level_t top);
    return (raw > top) ? top : raw;
  endfunction

endpackage

// File: rtl/fifo_prio_queue.sv
// One circular buffer of DEPTH words; pointers wrap explicitly so any depth works.
module fifo_prio_queue
  import fifo_prio_pkg::*;
#(
  parameter int DW    = 34,
  parameter int DEPTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int CW = cntWidth(DEPTH);
  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          doPush, doPop;

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    if (doPush) wrPtr_d = (wrPtr_q == AW'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = (rdPtr_q == AW'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
    case ({doPush, doPop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage is not reset; emptiness is carried entirely by cnt_q.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= din;
  end

endmodule

// File: rtl/fifo_multi_priority.sv
// Multi-level priority FIFO: per-level queues, strict priority output with aging
// that forces service of a level bypassed AGE_LIMIT times.
module fifo_multi_priority
  import fifo_prio_pkg::*;
#(
  parameter int DW        = 34,
  parameter int NUM_PRIO  = 4,
  parameter int DEPTH     = 5,
  parameter int AGE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       data_in,
  input  logic                vld_i,
  output logic                rdy_o,
  output logic [DW-1:0]       data_out,
  output logic                vld_o,
  input  logic                rdy_i,
  output logic [NUM_PRIO-1:0] full_o,
  output logic [NUM_PRIO-1:0] empty_o
);

  localparam int              PW       = prioWidth(NUM_PRIO);
  localparam int              WW       = waitWidth(AGE_LIMIT);
  localparam logic [WW-1:0]   AGE_MAX  = WW'(AGE_LIMIT);
  localparam bit              AGING_ON = (AGE_LIMIT != 0);

  level_t              wrLevel;
  logic [NUM_PRIO-1:0] wrOh, pushVec, popVec, selOh;
  logic [PW-1:0]       sel, ageSel;
  logic                ageHit, pop;
  logic [DW-1:0]       qDout [NUM_PRIO];
  logic [DW-1:0]       dataMux;
  logic [WW-1:0]       waitCnt_q [NUM_PRIO];
  logic [WW-1:0]       waitCnt_d [NUM_PRIO];

  // Out-of-range level fields fold onto the top level.
  assign wrLevel = clampLevel(level_t'(data_in[DW-1 -: PW]), level_t'(NUM_PRIO - 1));
  assign rdy_o   = |(wrOh & ~full_o);
  assign vld_o   = ~&empty_o;
  assign pop     = vld_o && rdy_i;

  for (genvar l = 0; l < NUM_PRIO; l++) begin : gLevel
    assign wrOh[l]    = (wrLevel == level_t'(l));
    assign pushVec[l] = vld_i && wrOh[l] && !full_o[l];
    assign popVec[l]  = pop && selOh[l];

    fifo_prio_queue #(
      .DW   (DW),
      .DEPTH(DEPTH)
    ) uQueue (
      .clk  (clk),
      .rst  (rst),
      .push (pushVec[l]),
      .pop  (popVec[l]),
      .din  (data_in),
      .dout (qDout[l]),
      .full (full_o[l]),
      .empty(empty_o[l])
    );
  end

  // Highest starved level wins; otherwise highest non-empty level.
  always_comb begin
    sel    = '0;
    ageSel = '0;
    ageHit = 1'b0;
    selOh  = '0;
    for (int l = 0; l < NUM_PRIO; l++) begin
      if (!empty_o[l]) sel = PW'(l);
      if (AGING_ON && (waitCnt_q[l] == AGE_MAX)) begin
        ageHit = 1'b1;
        ageSel = PW'(l);
      end
    end
    if (ageHit) sel = ageSel;
    for (int l = 0; l < NUM_PRIO; l++) begin
      if (sel == PW'(l)) selOh[l] = 1'b1;
    end
  end

  always_comb begin
    dataMux = '0;
    for (int l = 0; l < NUM_PRIO; l++) begin
      if (selOh[l]) dataMux = dataMux | qDout[l];
    end
  end

  assign data_out = vld_o ? dataMux : '0;

  always_comb begin
    waitCnt_d = waitCnt_q;
    for (int l = 0; l < NUM_PRIO; l++) begin
      if (empty_o[l] || !AGING_ON) begin
        waitCnt_d[l] = '0;
      end else if (pop) begin
        if (selOh[l]) waitCnt_d[l] = '0;
        else if (waitCnt_q[l] != AGE_MAX) waitCnt_d[l] = waitCnt_q[l] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < NUM_PRIO; l++) waitCnt_q[l] <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_multi_priority.sv
// Directed bench: three instances cover strict priority, aging and a 3-level config.
module tb_fifo_multi_priority;

  localparam int DW = 34;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] din0, dout0, din1, dout1, din2, dout2;
  logic          vi0, ro0, vo0, ri0;
  logic          vi1, ro1, vo1, ri1;
  logic          vi2, ro2, vo2, ri2;
  logic [3:0]    f0, e0, f1, e1;
  logic [2:0]    f2, e2;

  fifo_multi_priority #(.DW(DW), .NUM_PRIO(4), .DEPTH(5), .AGE_LIMIT(0)) u0 (
    .clk(clk), .rst(rst), .data_in(din0), .vld_i(vi0), .rdy_o(ro0), .data_out(dout0),
    .vld_o(vo0), .rdy_i(ri0), .full_o(f0), .empty_o(e0));

  fifo_multi_priority #(.DW(DW), .NUM_PRIO(4), .DEPTH(5), .AGE_LIMIT(2)) u1 (
    .clk(clk), .rst(rst), .data_in(din1), .vld_i(vi1), .rdy_o(ro1), .data_out(dout1),
    .vld_o(vo1), .rdy_i(ri1), .full_o(f1), .empty_o(e1));

  fifo_multi_priority #(.DW(DW), .NUM_PRIO(3), .DEPTH(5), .AGE_LIMIT(0)) u2 (
    .clk(clk), .rst(rst), .data_in(din2), .vld_i(vi2), .rdy_o(ro2), .data_out(dout2),
    .vld_o(vo2), .rdy_i(ri2), .full_o(f2), .empty_o(e2));

  function automatic logic [DW-1:0] mk(input logic [1:0] lvl, input logic [31:0] pay);
    return {lvl, pay};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [DW-1:0] w);
    din0 = w; vi0 = 1'b1; step(); vi0 = 1'b0;
  endtask

  task automatic push1(input logic [DW-1:0] w);
    din1 = w; vi1 = 1'b1; step(); vi1 = 1'b0;
  endtask

  task automatic push2(input logic [DW-1:0] w);
    din2 = w; vi2 = 1'b1; step(); vi2 = 1'b0;
  endtask

  // Reset values, then an asynchronous reset dropped in the middle of a stream.
  task automatic test_reset();
    rst = 1'b0;
    din0 = '0; din1 = '0; din2 = '0;
    vi0 = 1'b0; vi1 = 1'b0; vi2 = 1'b0;
    ri0 = 1'b0; ri1 = 1'b0; ri2 = 1'b0;
    #2;
    checks++; if (vo0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got=%b exp=0", vo0); end
    checks++; if (e0 !== 4'hF) begin errors++; $display("[TB] FAIL reset_empty got=%b exp=1111", e0); end
    checks++; if (f0 !== 4'h0) begin errors++; $display("[TB] FAIL reset_full got=%b exp=0000", f0); end
    checks++; if (dout0 !== '0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", dout0); end
    checks++; if (ro0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy got=%b exp=1", ro0); end
    checks++; if (e2 !== 3'b111) begin errors++; $display("[TB] FAIL reset_empty3 got=%b exp=111", e2); end
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) push0(mk(2'd2, 32'h2000_0000 + 32'(i)));
    checks++; if (vo0 !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_vld got=%b exp=1", vo0); end
    checks++; if (dout0 !== mk(2'd2, 32'h2000_0000)) begin errors++; $display("[TB] FAIL pre_rst_data got=%h exp=%h", dout0, mk(2'd2, 32'h2000_0000)); end
    checks++; if (e0 !== 4'b1011) begin errors++; $display("[TB] FAIL pre_rst_empty got=%b exp=1011", e0); end
    #3; rst = 1'b0; #1;
    checks++; if (vo0 !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_vld got=%b exp=0", vo0); end
    checks++; if (e0 !== 4'hF) begin errors++; $display("[TB] FAIL async_rst_empty got=%b exp=1111", e0); end
    checks++; if (dout0 !== '0) begin errors++; $display("[TB] FAIL async_rst_data got=%h exp=0", dout0); end
    din0 = mk(2'd2, 32'h2000_00AA); vi0 = 1'b1; step();
    checks++; if (e0 !== 4'hF) begin errors++; $display("[TB] FAIL push_in_rst got=%b exp=1111", e0); end
    vi0 = 1'b0; #2; rst = 1'b1; step();
    checks++; if (vo0 !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_vld got=%b exp=0", vo0); end
    checks++; if (e0 !== 4'hF) begin errors++; $display("[TB] FAIL post_rst_empty got=%b exp=1111", e0); end
  endtask

  // Highest level first; FIFO order inside a level.
  task automatic test_strict();
    logic [DW-1:0] exp [3];
    exp = '{mk(2'd3, 32'hB), mk(2'd1, 32'hC), mk(2'd0, 32'hA)};
    push0(mk(2'd0, 32'hA)); push0(mk(2'd3, 32'hB)); push0(mk(2'd1, 32'hC));
    checks++; if (e0 !== 4'b0100) begin errors++; $display("[TB] FAIL strict_empty got=%b exp=0100", e0); end
    ri0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dout0 !== exp[i]) begin errors++; $display("[TB] FAIL strict_read%0d got=%h exp=%h", i, dout0, exp[i]); end
      step();
    end
    ri0 = 1'b0;
    checks++; if (vo0 !== 1'b0) begin errors++; $display("[TB] FAIL strict_drained got=%b exp=0", vo0); end
    push0(mk(2'd1, 32'hD1)); push0(mk(2'd1, 32'hD2));
    ri0 = 1'b1;
    checks++; if (dout0 !== mk(2'd1, 32'hD1)) begin errors++; $display("[TB] FAIL order_first got=%h exp=%h", dout0, mk(2'd1, 32'hD1)); end
    step();
    checks++; if (dout0 !== mk(2'd1, 32'hD2)) begin errors++; $display("[TB] FAIL order_second got=%h exp=%h", dout0, mk(2'd1, 32'hD2)); end
    step(); ri0 = 1'b0;
  endtask

  // Fill level 1, refuse a 6th push, then wrap the pointers.
  task automatic test_full_wrap();
    for (int i = 0; i < 5; i++) push0(mk(2'd1, 32'h100 + 32'(i)));
    checks++; if (f0 !== 4'b0010) begin errors++; $display("[TB] FAIL full_flag got=%b exp=0010", f0); end
    checks++; if (e0 !== 4'b1101) begin errors++; $display("[TB] FAIL full_empty got=%b exp=1101", e0); end
    din0 = mk(2'd1, 32'h1FF); vi0 = 1'b1; #1;
    checks++; if (ro0 !== 1'b0) begin errors++; $display("[TB] FAIL full_rdy got=%b exp=0", ro0); end
    step(); vi0 = 1'b0;
    checks++; if (dout0 !== mk(2'd1, 32'h100)) begin errors++; $display("[TB] FAIL full_head got=%h exp=%h", dout0, mk(2'd1, 32'h100)); end
    ri0 = 1'b1; step(); step(); ri0 = 1'b0;
    checks++; if (f0 !== 4'b0000) begin errors++; $display("[TB] FAIL after_pop_full got=%b exp=0000", f0); end
    push0(mk(2'd1, 32'h105)); push0(mk(2'd1, 32'h106));
    checks++; if (f0 !== 4'b0010) begin errors++; $display("[TB] FAIL refill_full got=%b exp=0010", f0); end
    ri0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (dout0 !== mk(2'd1, 32'h102 + 32'(i))) begin errors++; $display("[TB] FAIL wrap_read%0d got=%h exp=%h", i, dout0, mk(2'd1, 32'h102 + 32'(i))); end
      step();
    end
    ri0 = 1'b0;
    checks++; if (vo0 !== 1'b0) begin errors++; $display("[TB] FAIL wrap_drained got=%b exp=0", vo0); end
  endtask

  // Push and pop together on a full level: only the pop happens.
  task automatic test_push_pop_full();
    for (int i = 0; i < 5; i++) push0(mk(2'd3, 32'h300 + 32'(i)));
    checks++; if (f0 !== 4'b1000) begin errors++; $display("[TB] FAIL ppf_full got=%b exp=1000", f0); end
    din0 = mk(2'd3, 32'h305); vi0 = 1'b1; ri0 = 1'b1; #1;
    checks++; if (ro0 !== 1'b0) begin errors++; $display("[TB] FAIL ppf_rdy_full got=%b exp=0", ro0); end
    step(); ri0 = 1'b0;
    checks++; if (f0 !== 4'b0000) begin errors++; $display("[TB] FAIL ppf_after got=%b exp=0000", f0); end
    checks++; if (dout0 !== mk(2'd3, 32'h301)) begin errors++; $display("[TB] FAIL ppf_head got=%h exp=%h", dout0, mk(2'd3, 32'h301)); end
    checks++; if (ro0 !== 1'b1) begin errors++; $display("[TB] FAIL ppf_rdy_next got=%b exp=1", ro0); end
    step(); vi0 = 1'b0;
    checks++; if (f0 !== 4'b1000) begin errors++; $display("[TB] FAIL ppf_refull got=%b exp=1000", f0); end
    ri0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (dout0 !== mk(2'd3, 32'h301 + 32'(i))) begin errors++; $display("[TB] FAIL ppf_read%0d got=%h exp=%h", i, dout0, mk(2'd3, 32'h301 + 32'(i))); end
      step();
    end
    ri0 = 1'b0;
  endtask

  // One push and one pop per cycle on the same level keeps the count steady.
  task automatic test_back_to_back();
    push0(mk(2'd2, 32'h200));
    for (int i = 1; i < 5; i++) begin
      din0 = mk(2'd2, 32'h200 + 32'(i)); vi0 = 1'b1; ri0 = 1'b1;
      checks++; if (dout0 !== mk(2'd2, 32'h200 + 32'(i - 1))) begin errors++; $display("[TB] FAIL b2b_read%0d got=%h exp=%h", i, dout0, mk(2'd2, 32'h200 + 32'(i - 1))); end
      step();
    end
    vi0 = 1'b0; ri0 = 1'b0;
    checks++; if (e0 !== 4'b1011) begin errors++; $display("[TB] FAIL b2b_empty got=%b exp=1011", e0); end
    checks++; if (dout0 !== mk(2'd2, 32'h204)) begin errors++; $display("[TB] FAIL b2b_last got=%h exp=%h", dout0, mk(2'd2, 32'h204)); end
    ri0 = 1'b1; step(); ri0 = 1'b0;
    checks++; if (vo0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained got=%b exp=0", vo0); end
  endtask

  // AGE_LIMIT=2: level 0 is forced out after two bypasses, and its counter restarts.
  task automatic test_aging();
    logic [DW-1:0] exp [7];
    exp = '{mk(2'd3, 32'hB0), mk(2'd3, 32'hB1), mk(2'd0, 32'hA0), mk(2'd3, 32'hB2),
            mk(2'd3, 32'hB3), mk(2'd0, 32'hA1), mk(2'd3, 32'hB4)};
    push1(mk(2'd0, 32'hA0)); push1(mk(2'd0, 32'hA1));
    for (int i = 0; i < 5; i++) push1(mk(2'd3, 32'hB0 + 32'(i)));
    checks++; if (f1 !== 4'b1000) begin errors++; $display("[TB] FAIL age_full got=%b exp=1000", f1); end
    checks++; if (ro1 !== 1'b0) begin errors++; $display("[TB] FAIL age_rdy got=%b exp=0", ro1); end
    ri1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++; if (dout1 !== exp[i]) begin errors++; $display("[TB] FAIL age_read%0d got=%h exp=%h", i, dout1, exp[i]); end
      step();
    end
    ri1 = 1'b0;
    checks++; if (e1 !== 4'hF) begin errors++; $display("[TB] FAIL age_drained got=%b exp=1111", e1); end
  endtask

  // NUM_PRIO=3: level field 3 lands in level 2.
  task automatic test_out_of_range();
    push2(mk(2'd3, 32'hC0));
    checks++; if (e2 !== 3'b011) begin errors++; $display("[TB] FAIL oor_empty got=%b exp=011", e2); end
    checks++; if (dout2 !== mk(2'd3, 32'hC0)) begin errors++; $display("[TB] FAIL oor_data got=%h exp=%h", dout2, mk(2'd3, 32'hC0)); end
    for (int i = 1; i < 5; i++) push2(mk(2'd3, 32'hC0 + 32'(i)));
    checks++; if (f2 !== 3'b100) begin errors++; $display("[TB] FAIL oor_full got=%b exp=100", f2); end
    din2 = mk(2'd3, 32'hC5); vi2 = 1'b1; #1;
    checks++; if (ro2 !== 1'b0) begin errors++; $display("[TB] FAIL oor_rdy_full got=%b exp=0", ro2); end
    din2 = mk(2'd0, 32'hD0); #1;
    checks++; if (ro2 !== 1'b1) begin errors++; $display("[TB] FAIL oor_rdy_other got=%b exp=1", ro2); end
    step(); vi2 = 1'b0;
    checks++; if (e2 !== 3'b010) begin errors++; $display("[TB] FAIL oor_empty2 got=%b exp=010", e2); end
    ri2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [DW-1:0] w;
      w = (i < 5) ? mk(2'd3, 32'hC0 + 32'(i)) : mk(2'd0, 32'hD0);
      checks++; if (dout2 !== w) begin errors++; $display("[TB] FAIL oor_read%0d got=%h exp=%h", i, dout2, w); end
      step();
    end
    ri2 = 1'b0;
    checks++; if (vo2 !== 1'b0) begin errors++; $display("[TB] FAIL oor_drained got=%b exp=0", vo2); end
  endtask

  initial begin
    test_reset();
    test_strict();
    test_full_wrap();
    test_push_pop_full();
    test_back_to_back();
    test_aging();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_multi_priority.md
# fifo_multi_priority

Multi-level priority FIFO, generalising the single-bit priority FIFO to `NUM_PRIO` levels with bounded starvation of low levels. The top `PW` bits of each word select one of `NUM_PRIO` independent circular queues. The output always presents the head of the highest non-empty level, unless the aging rule forces service of a starved level. It sits between a valid/ready producer and consumer on the same clock.

## Interface

**Parameters**
- `DW`, default 34: word width, priority field included.
- `NUM_PRIO`, default 4: number of priority levels, ≥2. Level `NUM_PRIO-1` is the highest.
- `DEPTH`, default 5: entries per level, ≥2. Non-power-of-two is legal.
- `AGE_LIMIT`, default 8: bypass count that forces service of a waiting level. 0 disables aging (pure strict priority).

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `data_in` in DW: write word. `data_in[DW-1 -: PW]` is the level, `PW = $clog2(NUM_PRIO)`.
- `vld_i` in 1: write request.
- `rdy_o` out 1: target level of current `data_in` is not full.
- `data_out` out DW: head word of the selected level, priority field intact.
- `vld_o` out 1: some level is non-empty.
- `rdy_i` in 1: read accept.
- `full_o` out NUM_PRIO: per-level full flags.
- `empty_o` out NUM_PRIO: per-level empty flags.

## Operation

**Write**
- Push occurs when `vld_i && rdy_o` at a rising edge.
- A level field ≥ `NUM_PRIO` (possible when NUM_PRIO is not a power of two) maps to level `NUM_PRIO-1`.

**Read**
- Pop occurs when `vld_o && rdy_i`, always from the selected level `sel`.

**Selection** (combinational from registered state)
- If any level has `wait_cnt == AGE_LIMIT` (AGE_LIMIT ≠ 0), `sel` is the highest such level.
- Otherwise `sel` is the highest non-empty level.

**Aging**
- Each level has a `wait_cnt` of width `$clog2(AGE_LIMIT+1)`.
- On a pop from `sel`, every other non-empty level's counter increments, saturating at AGE_LIMIT.
- The popped level's counter clears. Empty levels hold their counter at 0.

**Queue mechanics**
- Each level keeps `wr_ptr`, `rd_ptr` and `cnt`, with `cnt` of width `$clog2(DEPTH+1)`.
- Pointers wrap explicitly from DEPTH-1 to 0.
- `full_o[l] = (cnt == DEPTH)`, `empty_o[l] = (cnt == 0)`.

**Boundary rules**
- Push and pop on the same level in one cycle: `cnt` is unchanged and both pointers advance.
- Full level: `rdy_o=0` even if a pop from that level happens in the same cycle. There is no write-through when full.
- Empty FIFO: a push is not visible on the output in the same cycle; there is no bypass path.
- Pushes to non-full levels are accepted regardless of other levels.

## Timing

**Reset**
- Asserting `rst` low at any time, including mid-transfer, immediately clears all pointers, counts and `wait_cnt`, and discards contents.
- During reset: `vld_o=0`, `empty_o` all 1, `full_o` all 0, `data_out` all 0.
- `rdy_o=1` during reset; writes are ignored until `rst` is high at a rising edge.

**Latency**
- A word pushed at edge N appears on `data_out` with `vld_o=1` after edge N, if it is `sel`.
- `data_out` changes only after an edge, on a pop or a `sel` change.
- Throughput: one push and one pop per cycle.

**Handshakes**
- `rdy_o` depends combinationally on `data_in`. Producers must hold `data_in` stable while `vld_i` is high.
- `vld_o` and `data_out` do not depend on `rdy_i` in the same cycle.

## Structure

- Package `fifo_prio_pkg` holds the `PW` helper function, the width functions for `cnt`/`wait_cnt`, and a `level_t` typedef.
- Sub-module `fifo_prio_queue`: one circular buffer with ports `push`, `pop`, `din`, `dout`, `full`, `empty`. It is instantiated `NUM_PRIO` times in a generate loop.
- The top level holds the write decode, the aging counters, the selection logic and the output mux.

## Test plan

1. **Reset mid-stream.** Push 3 words to level 2, drop `rst` between edges → outputs go to reset values asynchronously. After release, `vld_o=0` and `empty_o=4'b1111`.
2. **Strict order.** With AGE_LIMIT=0, push level-0 word `A`, then level-3 word `B`, then level-1 word `C`, then read 3 → order is `B`, `C`, `A`. FIFO order within a level is preserved.
3. **Full/wrap.** Push 5 words to level 1 → `full_o[1]=1` and a 6th push sees `rdy_o=0`. Pop 2 and push 2 → pointers wrap and all 5 words read back in order.
4. **Simultaneous push/pop on full level.** With level 3 full, `vld_i` and `rdy_i` both high for level 3 → pop only, `cnt` becomes 4. The next cycle's push is accepted.
5. **Aging.** AGE_LIMIT=2, level 0 holds `X`, level 3 is kept non-empty, read continuously → `X` is delivered as the 3rd read word. Its `wait_cnt` then returns to 0.
6. **Out-of-range priority.** NUM_PRIO=3 with level field 3 → the word lands in level 2 and `full_o[2]` tracks it.
